mbscore_irq_arbiter: RTL and testbench
======================================

Name: mbscore_irq_arbiter

Overview:
- Front end of the core interrupt path; sits directly upstream of the interrupt controller.
- Synchronises raw device request lines, edge-detects and latches them as pending, applies a software mask and selects one source by fixed priority.
- Presents the selected source as an encoded `int_vec`, held stable until the core acknowledges.
- Also records overrun (event lost while already pending) per source.

Parameters:
- `NSRC`, 5, number of request sources (0 keyboard, 1 mouse, 2 uart, 3 storage, 4 ethernet).
- `SEL_W`, 3, width of `int_vec` code; must hold `NSRC`.
- `SYNC_STAGES`, 2, flip-flop stages on each raw request line (min 2).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `irq_raw`  in  NSRC  raw device requests; asynchronous, level, active-high.
- `mask_we`  in  1  write strobe for mask register.
- `mask_wdata`  in  NSRC  new mask; bit=1 blocks source.
- `int_ack`  in  1  one-cycle pulse from core: presented interrupt taken.
- `int_vec`  out  SEL_W  0 = none; k+1 = source k requesting.
- `int_pending`  out  NSRC  pending register, unmasked view.
- `int_mask`  out  NSRC  current mask.
- `int_ovf`  out  NSRC  sticky overrun flags.
- `ovf_clr`  in  NSRC  write-1-to-clear for `int_ovf`.

Behaviour:
- **Reset:** `rst` high clears, asynchronously, all sync stages, edge history, `int_pending`, `int_ovf` and `int_vec`. It sets `int_mask` to all ones (everything blocked). FSM goes to IDLE. Any presentation in progress is dropped.
- **Synchronisation:** `SYNC_STAGES` flops per line. The edge is detected on the synced value vs. its previous value (0→1). A pulse shorter than one clock may be missed; this is accepted.
- **Pending:** an edge on source k sets `pend[k]`. `pend[k]` clears only on acknowledge of k.
  - An edge on k in the same cycle as the ack of k leaves `pend[k]` = 1.
  - An edge on k while `pend[k]` is already 1, with no ack of k that cycle, sets `int_ovf[k]`.
  - `ovf_clr[k]` clears `int_ovf[k]`. A set and a clear in the same cycle result in set.
- **Mask:** `mask_we` loads `mask_wdata` next edge. The mask does not stop latching; masked sources still pend. A source is eligible when `pend[k] & ~mask[k]`.
- **Priority:** lowest index wins (keyboard highest).
- **FSM:**
  - IDLE: `int_vec` = 0. If any eligible source, register the winner w and go to PRESENT next cycle, with `int_vec` = w+1 from that edge. Selection-to-output latency is 1 clk; raw edge to `int_vec` is `SYNC_STAGES`+2 clk.
  - PRESENT: `int_vec` held constant; no re-arbitration, even if a higher-priority source pends or w becomes masked. On `int_ack`: clear `pend[w]`, `int_vec` → 0 next edge, go to GAP.
  - GAP: `int_vec` = 0 for exactly one cycle, then IDLE. `int_ack` here is ignored.
- `int_ack` in IDLE is ignored with no state change.
- All outputs are registered. No combinational path from input to output.

Test Plan:
- **Reset defaults:** `rst` pulse → `int_vec`=0, `int_mask`=5'b11111, `int_pending`=0, `int_ovf`=0. Then a `irq_raw[2]` pulse with the mask still all ones → `int_pending`=5'b00100 and `int_vec` stays 0.
- **Basic uart request:** write `mask`=0, raise `irq_raw[2]` → `int_vec`=3 exactly 4 clk after the synced edge path, stable until `int_ack`. After ack: `int_vec`=0 for 1 clk, `pend[2]`=0.
- **Priority and hold:**
  - Raise sources 4 and 1 together → `int_vec`=2 first.
  - While presenting, raise source 0 → `int_vec` stays 2 until ack.
  - Then GAP, then `int_vec`=1, then `int_vec`=5 after the next ack/GAP.
- **Overrun:**
  - Edge on source 3 twice before ack → `int_ovf[3]`=1 and `pend[3]` remains 1.
  - An edge coinciding with `ack` of 3 → `pend[3]` stays 1 and `int_vec`=4 again after GAP; no ovf.
  - `ovf_clr[3]`=1 → `int_ovf[3]`=0.
- **Ack outside PRESENT:** `int_ack` in IDLE and in GAP → no state change, no pending cleared.
- **Reset mid-operation:** assert `rst` asynchronously (mid-cycle) while in PRESENT with `int_vec`=3 → `int_vec`=0 immediately, without waiting for a clk edge. After release, nothing presents until the mask is written.

Source files
------------

// File: rtl/mbscore_irq_arbiter.sv
// Interrupt front end: per-source synchroniser, edge latch and overrun flag,
// followed by a software mask, fixed-priority pick and a present/ack/gap handshake.

module mbscore_irq_src #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_raw_i,
    input  logic ack_clr_i,
    input  logic ovf_clr_i,
    output logic pend_o,
    output logic ovf_o
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;
    logic                   pend_q, pend_d;
    logic                   ovf_q, ovf_d;
    logic                   rise;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_raw_i};
        rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
        // A fresh edge wins over a same-cycle ack, so the event is never lost.
        pend_d = (pend_q & ~ack_clr_i) | rise;
        // Set beats clear so an overrun in the clearing cycle stays visible.
        ovf_d  = (ovf_q & ~ovf_clr_i) | (rise & pend_q & ~ack_clr_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pend_o = pend_q;
    assign ovf_o  = ovf_q;
endmodule

module mbscore_irq_arbiter #(
    parameter int NSRC        = 5,
    parameter int SEL_W       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSRC-1:0]  irq_raw,
    input  logic             mask_we,
    input  logic [NSRC-1:0]  mask_wdata,
    input  logic             int_ack,
    output logic [SEL_W-1:0] int_vec,
    output logic [NSRC-1:0]  int_pending,
    output logic [NSRC-1:0]  int_mask,
    output logic [NSRC-1:0]  int_ovf,
    input  logic [NSRC-1:0]  ovf_clr
);
    typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAP} state_t;

    state_t           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] int_vec_q;
    logic [NSRC-1:0]  mask_q, mask_d;
    logic [NSRC-1:0]  pend, ovf, elig, ack_clr;
    logic [SEL_W-1:0] win;
    logic             any_elig;
    logic             ack_fire;

    assign ack_fire = (state_q == S_PRESENT) & int_ack;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        assign ack_clr[g] = ack_fire & (sel_q == SEL_W'(g));

        mbscore_irq_src #(.SYNC_STAGES(SYNC_STAGES)) u_src (
            .clk       (clk),
            .rst       (rst),
            .irq_raw_i (irq_raw[g]),
            .ack_clr_i (ack_clr[g]),
            .ovf_clr_i (ovf_clr[g]),
            .pend_o    (pend[g]),
            .ovf_o     (ovf[g])
        );
    end

    // Masking only gates eligibility; masked sources keep latching.
    always_comb begin
        elig     = pend & ~mask_q;
        any_elig = |elig;
        win      = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (elig[k]) win = SEL_W'(k);
        end
        mask_d = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mask_q <= '1;
        else     mask_q <= mask_d;
    end

    // The presented source is frozen in sel_q until acked; no re-arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            int_vec_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_elig) begin
                        sel_q     <= win;
                        int_vec_q <= win + SEL_W'(1);
                        state_q   <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (int_ack) begin
                        int_vec_q <= '0;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    int_vec_q <= '0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    int_vec_q <= '0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign int_vec     = int_vec_q;
    assign int_pending = pend;
    assign int_mask    = mask_q;
    assign int_ovf     = ovf;
endmodule

// File: tb/tb_mbscore_irq_arbiter.sv
// Directed bench for mbscore_irq_arbiter with hand-computed expectations.

module tb_mbscore_irq_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] irq_raw;
    logic       mask_we;
    logic [4:0] mask_wdata;
    logic       int_ack;
    logic [2:0] int_vec;
    logic [4:0] int_pending;
    logic [4:0] int_mask;
    logic [4:0] int_ovf;
    logic [4:0] ovf_clr;

    int n_run  = 0;
    int n_fail = 0;

    mbscore_irq_arbiter #(.NSRC(5), .SEL_W(3), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_raw     (irq_raw),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .int_ack     (int_ack),
        .int_vec     (int_vec),
        .int_pending (int_pending),
        .int_mask    (int_mask),
        .int_ovf     (int_ovf),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic write_mask(input logic [4:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_raw = '0; mask_we = 1'b0; mask_wdata = '0;
        int_ack = 1'b0; ovf_clr = '0;
        tick(3);
        rst = 1'b0;
        tick();

        // Reset defaults
        chk("rst_vec",  int_vec, 0);
        chk("rst_mask", int_mask, 5'b11111);
        chk("rst_pend", int_pending, 0);
        chk("rst_ovf",  int_ovf, 0);

        // Masked source still latches
        irq_raw[2] = 1'b1;
        tick(4);
        chk("masked_pend", int_pending, 5'b00100);
        chk("masked_vec",  int_vec, 0);
        irq_raw[2] = 1'b0;

        // Unmask: stale uart presents next edge; retire it
        write_mask('0);
        tick();
        chk("stale_vec", int_vec, 3);
        ack_pulse();
        chk("stale_gap", int_vec, 0);
        chk("stale_clr", int_pending, 0);
        tick(2);

        // Basic uart: raw edge to int_vec is 4 clocks
        irq_raw[2] = 1'b1;
        tick(3);
        chk("uart_pend_t3", int_pending, 5'b00100);
        chk("uart_vec_t3",  int_vec, 0);
        tick();
        chk("uart_vec_t4",  int_vec, 3);
        irq_raw[2] = 1'b0;
        tick(3);
        chk("uart_hold", int_vec, 3);
        ack_pulse();
        chk("uart_gap",  int_vec, 0);
        chk("uart_clr",  int_pending, 0);
        tick();
        chk("uart_idle", int_vec, 0);
        tick();

        // Priority and hold
        irq_raw = 5'b10010;
        tick(4);
        chk("pri_first", int_vec, 2);
        chk("pri_pend",  int_pending, 5'b10010);
        irq_raw = 5'b10011;
        tick(4);
        chk("pri_hold",      int_vec, 2);
        chk("pri_pend_all",  int_pending, 5'b10011);
        ack_pulse();
        chk("pri_gap1", int_vec, 0);
        tick();
        chk("pri_idle1", int_vec, 0);
        tick();
        chk("pri_second", int_vec, 1);
        ack_pulse();
        tick(2);
        chk("pri_third", int_vec, 5);
        ack_pulse();
        tick(2);
        chk("pri_empty", int_pending, 0);
        irq_raw = '0;
        tick(3);

        // Overrun on storage
        irq_raw[3] = 1'b1;
        tick(4);
        chk("ovf_vec", int_vec, 4);
        irq_raw[3] = 1'b0;
        tick(3);
        irq_raw[3] = 1'b1;
        tick(3);
        chk("ovf_set",  int_ovf, 5'b01000);
        chk("ovf_pend", int_pending, 5'b01000);
        chk("ovf_vec2", int_vec, 4);
        ovf_clr[3] = 1'b1;
        tick();
        ovf_clr[3] = 1'b0;
        chk("ovf_clr", int_ovf, 0);

        // Edge coinciding with ack of the same source
        irq_raw[3] = 1'b0;
        tick(3);
        irq_raw[3] = 1'b1;
        tick(2);
        ack_pulse();
        chk("coin_pend", int_pending, 5'b01000);
        chk("coin_ovf",  int_ovf, 0);
        chk("coin_gap",  int_vec, 0);
        tick(2);
        chk("coin_repr", int_vec, 4);
        ack_pulse();
        tick(2);
        chk("coin_done", int_pending, 0);
        irq_raw = '0;
        tick(3);

        // Ack in IDLE and in GAP is ignored
        write_mask(5'b11111);
        irq_raw = 5'b10010;
        tick(4);
        ack_pulse();
        chk("idle_ack_pend", int_pending, 5'b10010);
        chk("idle_ack_vec",  int_vec, 0);
        write_mask('0);
        tick();
        chk("gap_pre_vec", int_vec, 2);
        int_ack = 1'b1;
        tick();
        chk("gap_vec", int_vec, 0);
        tick();
        int_ack = 1'b0;
        chk("gap_ack_pend", int_pending, 5'b10000);
        tick();
        chk("gap_next_vec", int_vec, 5);
        ack_pulse();
        tick(2);
        irq_raw = '0;
        tick(3);

        // Asynchronous reset while presenting uart
        irq_raw[2] = 1'b1;
        tick(4);
        chk("mid_pre_vec", int_vec, 3);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_async_vec",  int_vec, 0);
        chk("mid_async_mask", int_mask, 5'b11111);
        chk("mid_async_pend", int_pending, 0);
        #2;
        rst = 1'b0;
        tick(5);
        chk("post_rst_vec",  int_vec, 0);
        chk("post_rst_pend", int_pending, 5'b00100);
        write_mask('0);
        tick();
        chk("post_rst_unmask", int_vec, 3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
